// File: rtl/iic_pkg.sv
// Shared state encoding and constants for the I2C target blocks.
package iic_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        WADDR,
        WADDR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } iic_state_e;

    // R/W flag sits in the LSB of the address byte
    localparam int RW_BIT     = 0;
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/iic_bus_sync.sv
// SCL/SDA synchronizers plus one history stage; derives SCL edges and START/STOP.
module iic_bus_sync
    import iic_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_DEPTH-1:0] scl_ff;
    logic [SYNC_DEPTH-1:0] sda_ff;
    logic                  scl_h;
    logic                  sda_h;
    logic                  scl_s;

    // Reset to the idle-bus level so leaving reset never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_h  <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_DEPTH-2:0], scl};
            sda_ff <= {sda_ff[SYNC_DEPTH-2:0], sda};
            scl_h  <= scl_ff[SYNC_DEPTH-1];
            sda_h  <= sda_ff[SYNC_DEPTH-1];
        end
    end

    assign scl_s    = scl_ff[SYNC_DEPTH-1];
    assign sda_s    = sda_ff[SYNC_DEPTH-1];
    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    // SCL must be high in both samples, so an SDA change coinciding with an SCL edge is not START/STOP
    assign start    = scl_s & scl_h & sda_h & ~sda_s;
    assign stop     = scl_s & scl_h & ~sda_h & sda_s;

endmodule

// File: rtl/iic_slave_recv.sv
// I2C target turning bus write transactions into single-cycle register write strobes.
// Build option IIC_SLAVE_READ_EN adds read transfers and the I_rd_data port.
module iic_slave_recv
    import iic_pkg::*;
#(
    parameter logic [6:0] C_DEV_ADDR  = 7'h50,
    parameter int         C_MIN_PHASE = 8
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_scl,
    inout  wire        IO_sda,
`ifdef IIC_SLAVE_READ_EN
    input  logic [7:0] I_rd_data,
`endif
    output logic       O_wr_en,
    output logic [7:0] O_word_addr,
    output logic [7:0] O_wr_data,
    output logic       O_busy
);

    iic_state_e state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sh;
    logic [7:0] rx_byte;
    logic       sda_oe;
    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       bus_start;
    logic       bus_stop;
    logic       addr_hit;
`ifdef IIC_SLAVE_READ_EN
    logic       rd_mode;
    logic       ack_seen;
    logic [7:0] tx_sh;
`endif

    // The ACK drive lands SYNC_DEPTH+1 cycles after SCL falls and must precede the next rise
    if (C_MIN_PHASE <= SYNC_DEPTH + 1) begin : g_min_phase_chk
        $error("C_MIN_PHASE too short for the synchronizer latency");
    end

    iic_bus_sync u_sync (
        .clk      (I_clk),
        .rst_n    (I_rst_n),
        .scl      (I_scl),
        .sda      (IO_sda),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (bus_start),
        .stop     (bus_stop)
    );

    assign rx_byte  = {rx_sh, sda_s};
    assign addr_hit = (rx_byte[7:1] == C_DEV_ADDR);
    assign IO_sda   = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            rx_sh       <= 7'd0;
            sda_oe      <= 1'b0;
            O_wr_en     <= 1'b0;
            O_word_addr <= 8'h00;
            O_wr_data   <= 8'h00;
            O_busy      <= 1'b0;
`ifdef IIC_SLAVE_READ_EN
            rd_mode     <= 1'b0;
            ack_seen    <= 1'b0;
            tx_sh       <= 8'h00;
`endif
        end else begin
            O_wr_en <= 1'b0;
            if (scl_rise) begin
                rx_sh <= rx_byte[6:0];
            end
            if (bus_stop) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                O_busy <= 1'b0;
            end else if (bus_start) begin
                state   <= DEV;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    DEV: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (addr_hit && !rx_byte[RW_BIT]) begin
                                    state  <= DEV_ACK;
                                    O_busy <= 1'b1;
`ifdef IIC_SLAVE_READ_EN
                                    rd_mode <= 1'b0;
                                end else if (addr_hit) begin
                                    state   <= DEV_ACK;
                                    O_busy  <= 1'b1;
                                    rd_mode <= 1'b1;
`endif
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    WADDR: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                O_word_addr <= rx_byte;
                                state       <= WADDR_ACK;
                            end
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                O_wr_data <= rx_byte;
                                O_wr_en   <= 1'b1;
                                state     <= WDATA_ACK;
                            end
                        end
                    end
                    // First SCL fall starts the ACK drive, the second one ends it
                    DEV_ACK, WADDR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                if (state == DEV_ACK) begin
                                    state <= WADDR;
`ifdef IIC_SLAVE_READ_EN
                                    if (rd_mode) begin
                                        tx_sh  <= I_rd_data;
                                        sda_oe <= ~I_rd_data[7];
                                        state  <= RDATA;
                                    end
`endif
                                end else if (state == WADDR_ACK) begin
                                    state <= WDATA;
                                end else begin
                                    O_word_addr <= O_word_addr + 8'd1;
                                    state       <= WDATA;
                                end
                            end
                        end
                    end
`ifdef IIC_SLAVE_READ_EN
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state    <= RDATA_ACK;
                                ack_seen <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            tx_sh  <= {tx_sh[6:0], 1'b0};
                            sda_oe <= ~tx_sh[6];
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                ack_seen    <= 1'b1;
                                O_word_addr <= O_word_addr + 8'd1;
                            end else begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall) begin
                            if (ack_seen) begin
                                tx_sh    <= I_rd_data;
                                sda_oe   <= ~I_rd_data[7];
                                ack_seen <= 1'b0;
                                state    <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                    end
`endif
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_slave_recv.sv
// Directed bench for iic_slave_recv: a bit-banged bus master plus a strobe recorder.
`timescale 1ns/1ps
module tb_iic_slave_recv;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl   = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic       wr_en;
    logic       busy;
    logic [7:0] word_addr;
    logic [7:0] wr_data;
`ifdef IIC_SLAVE_READ_EN
    logic [7:0] rd_data = 8'h5A;
`endif

    int         checks   = 0;
    int         errors   = 0;
    int         n_strobe = 0;
    logic [7:0] s_addr [16];
    logic [7:0] s_data [16];

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #10 clk = ~clk;

    iic_slave_recv dut (
        .I_clk       (clk),
        .I_rst_n     (rst_n),
        .I_scl       (scl),
        .IO_sda      (sda),
`ifdef IIC_SLAVE_READ_EN
        .I_rd_data   (rd_data),
`endif
        .O_wr_en     (wr_en),
        .O_word_addr (word_addr),
        .O_wr_data   (wr_data),
        .O_busy      (busy)
    );

    // A strobe longer than one cycle is recorded twice and shows up in the counts
    always @(negedge clk) begin
        if (wr_en) begin
            s_addr[n_strobe % 16] = word_addr;
            s_data[n_strobe % 16] = wr_data;
            n_strobe++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; wait_clk(5);
        scl   = 1'b1; wait_clk(5);
        m_low = 1'b1; wait_clk(5);
        scl   = 1'b0; wait_clk(5);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; wait_clk(5);
        scl   = 1'b1; wait_clk(5);
        m_low = 1'b0; wait_clk(10);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) begin
            m_low = ~b[i]; wait_clk(5);
            scl   = 1'b1;  wait_clk(10);
            scl   = 1'b0;  wait_clk(5);
        end
        m_low = 1'b0; wait_clk(5);
        scl   = 1'b1; wait_clk(5);
        acked = (sda === 1'b0);
        wait_clk(5);
        scl   = 1'b0; wait_clk(5);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic ack);
        m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(5);
            scl  = 1'b1; wait_clk(5);
            b[i] = (sda === 1'b0) ? 1'b0 : 1'b1;
            wait_clk(5);
            scl  = 1'b0; wait_clk(5);
        end
        m_low = ack;  wait_clk(5);
        scl   = 1'b1; wait_clk(10);
        scl   = 1'b0; wait_clk(5);
        m_low = 1'b0;
    endtask

    task automatic test_reset();
        wait_clk(5);
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rst_sda got %b want 1", sda); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
        checks++; if (word_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h want 00", word_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        rst_n = 1'b1;
        wait_clk(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b want 0", busy); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL post_rst_sda got %b want 1", sda); end
    endtask

    task automatic test_single_write();
        logic a0, a1, a2;
        int   base;
        base = n_strobe;
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h10, a1);
        send_byte(8'hA5, a2);
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL single_acks got %b want 111", {a0, a1, a2}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        bus_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_stop got %b want 0", busy); end
        checks++; if (n_strobe - base !== 1) begin errors++; $display("FAIL single_count got %0d want 1", n_strobe - base); end
        checks++; if (s_addr[base % 16] !== 8'h10) begin errors++; $display("FAIL single_addr got %h want 10", s_addr[base % 16]); end
        checks++; if (s_data[base % 16] !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", s_data[base % 16]); end
        checks++; if (word_addr !== 8'h11) begin errors++; $display("FAIL single_next_addr got %h want 11", word_addr); end
    endtask

    task automatic test_burst_wrap();
        logic       a;
        logic [7:0] exp_a [3];
        logic [7:0] exp_d [3];
        int         base;
        int         nack;
        exp_a = '{8'hFE, 8'hFF, 8'h00};
        exp_d = '{8'h11, 8'h22, 8'h33};
        base  = n_strobe;
        nack  = 0;
        bus_start();
        send_byte(8'hA0, a); if (!a) nack++;
        send_byte(8'hFE, a); if (!a) nack++;
        for (int i = 0; i < 3; i++) begin
            send_byte(exp_d[i], a);
            if (!a) nack++;
        end
        bus_stop();
        checks++; if (nack !== 0) begin errors++; $display("FAIL burst_nacks got %0d want 0", nack); end
        checks++; if (n_strobe - base !== 3) begin errors++; $display("FAIL burst_count got %0d want 3", n_strobe - base); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (s_addr[(base + i) % 16] !== exp_a[i]) begin errors++; $display("FAIL burst_addr%0d got %h want %h", i, s_addr[(base + i) % 16], exp_a[i]); end
            checks++; if (s_data[(base + i) % 16] !== exp_d[i]) begin errors++; $display("FAIL burst_data%0d got %h want %h", i, s_data[(base + i) % 16], exp_d[i]); end
        end
        checks++; if (word_addr !== 8'h01) begin errors++; $display("FAIL burst_final_addr got %h want 01", word_addr); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        int   base;
        base = n_strobe;
        bus_start();
        send_byte(8'hA2, a0);
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL wrong_addr_ack got %b want 0", a0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrong_addr_busy got %b want 0", busy); end
        send_byte(8'h12, a1);
        checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL wrong_addr_ignore_ack got %b want 0", a1); end
        bus_stop();
        checks++; if (n_strobe - base !== 0) begin errors++; $display("FAIL wrong_addr_strobes got %0d want 0", n_strobe - base); end
    endtask

    task automatic test_repeated_start();
        logic a0, a1, a2, a3, a4;
        int   base;
        base = n_strobe;
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h20, a1);
        bus_start();
        send_byte(8'hA0, a2);
        send_byte(8'h44, a3);
        send_byte(8'h3C, a4);
        bus_stop();
        checks++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin errors++; $display("FAIL rstart_acks got %b want 11111", {a0, a1, a2, a3, a4}); end
        checks++; if (n_strobe - base !== 1) begin errors++; $display("FAIL rstart_count got %0d want 1", n_strobe - base); end
        checks++; if (s_addr[base % 16] !== 8'h44) begin errors++; $display("FAIL rstart_addr got %h want 44", s_addr[base % 16]); end
        checks++; if (s_data[base % 16] !== 8'h3C) begin errors++; $display("FAIL rstart_data got %h want 3c", s_data[base % 16]); end
    endtask

    task automatic test_reset_mid();
        logic       a0, a1, a2, a3, a4, a5;
        logic [7:0] d;
        int         base;
        base = n_strobe;
        d    = 8'h9C;
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h70, a1);
        for (int i = 7; i >= 5; i--) begin
            m_low = ~d[i]; wait_clk(5);
            scl   = 1'b1;  wait_clk(10);
            scl   = 1'b0;  wait_clk(5);
        end
        m_low = ~d[4]; wait_clk(5);
        scl   = 1'b1;  wait_clk(5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        wait_clk(1);
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL mid_sda got %b want 1", sda); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (word_addr !== 8'h00) begin errors++; $display("FAIL mid_addr got %h want 00", word_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL mid_data got %h want 00", wr_data); end
        rst_n = 1'b1;
        wait_clk(4);
        scl   = 1'b0; wait_clk(5);
        for (int i = 3; i >= 0; i--) begin
            m_low = ~d[i]; wait_clk(5);
            scl   = 1'b1;  wait_clk(10);
            scl   = 1'b0;  wait_clk(5);
        end
        m_low = 1'b0; wait_clk(5);
        scl   = 1'b1; wait_clk(5);
        a2 = (sda === 1'b0);
        wait_clk(5);
        scl   = 1'b0; wait_clk(5);
        checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL mid_ignored_ack got %b want 0", a2); end
        bus_stop();
        checks++; if (n_strobe - base !== 0) begin errors++; $display("FAIL mid_strobes got %0d want 0", n_strobe - base); end
        bus_start();
        send_byte(8'hA0, a3);
        send_byte(8'h05, a4);
        send_byte(8'h99, a5);
        bus_stop();
        checks++; if ({a0, a1, a3, a4, a5} !== 5'b11111) begin errors++; $display("FAIL mid_acks got %b want 11111", {a0, a1, a3, a4, a5}); end
        checks++; if (n_strobe - base !== 1) begin errors++; $display("FAIL mid_after_count got %0d want 1", n_strobe - base); end
        checks++; if (s_addr[base % 16] !== 8'h05) begin errors++; $display("FAIL mid_after_addr got %h want 05", s_addr[base % 16]); end
        checks++; if (s_data[base % 16] !== 8'h99) begin errors++; $display("FAIL mid_after_data got %h want 99", s_data[base % 16]); end
    endtask

`ifdef IIC_SLAVE_READ_EN
    task automatic test_read();
        logic       a0, a1, a2;
        logic [7:0] b0, b1;
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h33, a1);
        bus_start();
        send_byte(8'hA1, a2);
        recv_byte(b0, 1'b1);
        recv_byte(b1, 1'b0);
        wait_clk(5);
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL read_acks got %b want 111", {a0, a1, a2}); end
        checks++; if (b0 !== 8'h5A) begin errors++; $display("FAIL read_byte0 got %h want 5a", b0); end
        checks++; if (b1 !== 8'h5A) begin errors++; $display("FAIL read_byte1 got %h want 5a", b1); end
        checks++; if (word_addr !== 8'h34) begin errors++; $display("FAIL read_addr got %h want 34", word_addr); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL read_sda_released got %b want 1", sda); end
        bus_stop();
    endtask
`else
    task automatic test_read_disabled();
        logic a0;
        bus_start();
        send_byte(8'hA1, a0);
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL read_nack got %b want 0", a0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy got %b want 0", busy); end
        bus_stop();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_wrong_addr();
        test_repeated_start();
        test_reset_mid();
`ifdef IIC_SLAVE_READ_EN
        test_read();
`else
        test_read_disabled();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
